// File: rtl/dashcam_pkg.sv
// Shared types for the camera capture path: word layout, FIFO entry and packer state.
package dashcam_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [8*BYTES_PER_WORD-1:0] word_t;

    // One FIFO slot: the packed word plus its framing attributes.
    typedef struct packed {
        word_t      data;
        logic [2:0] bytes;
        logic       sof;
        logic       last;
    } fifo_entry_t;

    // Packer frame state: idle waits for a start-of-frame byte, active assembles words.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } pk_state_t;

    // Return w with byte lane `lane` replaced by b (lane 0 = bits 7:0).
    function automatic word_t put_lane(input word_t w, input logic [1:0] lane,
                                       input logic [7:0] b);
        word_t r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/dashcam_sync_fifo.sv
// Show-ahead synchronous FIFO of fifo_entry_t; head entry is visible whenever !empty.
module dashcam_sync_fifo
    import dashcam_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fifo_entry_t              push_data,
    input  logic                     pop,
    output fifo_entry_t              pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fifo_entry_t     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    // A pop frees the slot a same-edge push needs, so push into a full FIFO is legal when popping.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer and occupancy registers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign level    = count;

endmodule

// File: rtl/cam_word_packer.sv
// Packs a framed camera byte stream into little-endian 32-bit words for a DMA consumer.
//
// Output handshake: a word is transferred on any clk edge where out_valid && out_ready.
// While out_valid is high and out_ready is low, out_data/out_bytes/out_sof/out_last hold.
// out_valid never drops without a transfer except on reset.
module cam_word_packer
    import dashcam_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [LEN_W-1:0]              frame_len,
    input  logic                          cam_valid,
    input  logic                          cam_sof,
    input  logic [7:0]                    cam_pixel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_data,
    output logic [2:0]                    out_bytes,
    output logic                          out_sof,
    output logic                          out_last,
    output logic [15:0]                   frame_count,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    pk_state_t        state;
    pk_state_t        state_d;
    logic [LEN_W-1:0] idx_q;
    logic [LEN_W-1:0] idx_d;
    logic [LEN_W-1:0] k;
    word_t            acc_q;
    word_t            acc_d;
    word_t            word_n;
    logic [1:0]       lane;
    logic             accept;
    logic             is_last;
    logic             push;
    logic             frame_done;
    fifo_entry_t      push_entry;
    fifo_entry_t      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    // Frame FSM and word assembly: index the byte, merge it into its lane, decide push/completion.
    always_comb begin
        state_d    = state;
        idx_d      = idx_q;
        acc_d      = acc_q;
        push       = 1'b0;
        frame_done = 1'b0;
        push_entry = '0;

        accept  = en && cam_valid && (frame_len != '0);
        // A start-of-frame byte is always byte 0, whatever was in progress.
        k       = cam_sof ? '0 : idx_q;
        lane    = k[1:0];
        word_n  = put_lane(cam_sof ? word_t'('0) : acc_q, lane, cam_pixel);
        is_last = (k == frame_len - LEN_W'(1));

        if (!en) begin
            // Capture disabled: abandon any frame and its partial word.
            state_d = ST_IDLE;
            acc_d   = '0;
            idx_d   = '0;
        end else if (accept && (cam_sof || state == ST_ACTIVE)) begin
            push             = (lane == 2'd3) || is_last;
            push_entry.data  = word_n;
            push_entry.bytes = (is_last && frame_len[1:0] != 2'b00) ? {1'b0, frame_len[1:0]}
                                                                    : 3'd4;
            push_entry.sof   = (k[LEN_W-1:2] == '0);
            push_entry.last  = is_last;
            // Clearing after a push keeps unused lanes of a short final word at zero.
            acc_d            = push ? '0 : word_n;
            idx_d            = k + LEN_W'(1);
            if (is_last) begin
                state_d    = ST_IDLE;
                frame_done = 1'b1;
            end else begin
                state_d    = ST_ACTIVE;
            end
        end
    end

    // Frame state, byte index, partial word and completed-frame counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            frame_count <= '0;
        end else begin
            state <= state_d;
            idx_q <= idx_d;
            acc_q <= acc_d;
            if (frame_done) frame_count <= frame_count + 16'd1;
        end
    end

    assign pop  = out_valid && out_ready;
    assign drop = push && fifo_full && !pop;

    // Sticky overflow: a drop on the same edge as ovf_clr wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    dashcam_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Outputs read zero when nothing is queued so stale storage never shows after reset.
    always_comb begin
        out_valid = !fifo_empty;
        out_data  = out_valid ? head.data  : '0;
        out_bytes = out_valid ? head.bytes : '0;
        out_sof   = out_valid ? head.sof   : 1'b0;
        out_last  = out_valid ? head.last  : 1'b0;
    end

endmodule

// File: doc/cam_word_packer.md
CAM_WORD_PACKER -- requirements
Module: cam_word_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning output word FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the frame length and byte counters.
REQ-003 SHALL have ports (clock and reset first; one clock; reset is synchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  capture enable (CSR cam_en)
- frame_len  in  LEN_W  bytes per frame (CSR 0x0c)
- cam_valid  in  1  pixel strobe
- cam_sof  in  1  start of frame, qualified by cam_valid
- cam_pixel  in  8  pixel byte
- out_valid  out  1  word available
- out_ready  in  1  consumer (DMA) accepts word
- out_data  out  32  packed word
- out_bytes  out  3  valid bytes in out_data (1-4)
- out_sof  out  1  first word of frame
- out_last  out  1  final word of frame
- frame_count  out  16  completed frames
- overflow  out  1  sticky FIFO-overflow flag
- ovf_clr  in  1  clears overflow
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words stored

Function
REQ-004 SHALL accept a byte on a clk edge iff en && cam_valid && frame_len != 0.
REQ-005 SHALL start a frame on an accepted byte with cam_sof=1: byte index reset to 0, and any partial word discarded without being pushed.
REQ-006 SHALL ignore accepted bytes without cam_sof while no frame is active, and ignore bytes after index frame_len-1 until the next cam_sof.
REQ-007 SHALL place frame byte k in lane k mod 4, i.e. out_data[8*lane+7:8*lane] (little-endian).
REQ-008 SHALL push the assembled word into the FIFO on the same edge that accepts its lane-3 byte or byte frame_len-1; out_valid SHALL rise the following cycle when the FIFO was empty.
REQ-009 SHALL zero unused lanes of a final partial word; out_bytes SHALL be 4 except on a partial final word, where it equals frame_len mod 4.
REQ-010 SHALL set out_sof on the word containing byte 0 and out_last on the word containing byte frame_len-1 (both set when frame_len<=4).
REQ-011 SHALL increment frame_count, mod 2^16, on the edge byte frame_len-1 is accepted, whether or not its word was dropped.
REQ-012 SHALL pop the FIFO on out_valid && out_ready; out_data, out_bytes, out_sof and out_last SHALL hold stable while out_valid && !out_ready.
REQ-013 SHALL allow push and pop on the same edge, including when full; a push into a full FIFO with no pop SHALL drop the word and set overflow.
REQ-014 SHALL keep byte counting and frame completion unaffected by a dropped word.
REQ-015 SHALL clear overflow on ovf_clr; a simultaneous set and clear SHALL leave overflow set.
REQ-016 SHALL abort an active frame when en deasserts: partial word discarded, frame inactive, no frame_count increment; FIFO contents remain drainable.
REQ-017 SHALL treat cam_sof during an active frame as an abort of the old frame plus a start of the new one.

Reset
REQ-018 SHALL, with rst_n=0 at a clk edge: empty the FIFO, deactivate the frame, discard the partial word, and zero frame_count, overflow, out_valid, out_data, out_bytes, out_sof, out_last and fifo_level.
REQ-019 SHALL apply reset mid-frame or mid-backpressure identically, with no words emitted afterwards from pre-reset data.

Structure
REQ-020 SHALL take BYTES_PER_WORD=4, the 32-bit word typedef and the FIFO entry struct {data, bytes, sof, last} from shared package dashcam_pkg.
REQ-021 SHALL implement the FIFO as sub-module dashcam_sync_fifo (show-ahead, synchronous reset, full/empty/level outputs).

Verification
REQ-022 SHALL cover: frame_len=64, bytes 0..63, out_ready=1 -> 16 words, first 32'h03020100 with out_sof, last 32'h3F3E3D3C with out_last, out_bytes=4, frame_count=1.
REQ-023 SHALL cover: frame_len=6 -> 32'h03020100 (out_bytes 4, out_sof), then 32'h00000504 (out_bytes 2, out_last).
REQ-024 SHALL cover: FIFO_DEPTH=8, out_ready=0, 64-byte frame -> fifo_level=8, overflow=1, frame_count=1; drain yields bytes 0..31 in order; ovf_clr -> overflow=0.
REQ-025 SHALL cover: cam_sof after 10 bytes of a 64-byte frame -> no out_last from the aborted frame, next word 32'h03020100 with out_sof, frame_count increments only on full completion.
REQ-026 SHALL cover: out_ready toggled every cycle during a 64-byte frame -> outputs held while stalled, 16 words in order, overflow=0.
REQ-027 SHALL cover: rst_n=0 for one edge after 20 bytes -> next cycle out_valid=0, fifo_level=0, frame_count=0; a following 8-byte frame yields exactly 2 words.
